phase_unfold: RTL and testbench

Back-end counterpart of `pattern_match` in the phase-extraction chain. `pattern_match` folds a complex sample into the first octant and emits an octant code `case_flag` ahead of the atan polynomial. `phase_unfold` buffers those codes, re-aligns each one with the polynomial result when it arrives, and expands the result back into a full-circle binary phase. It sits directly after the atan polynomial stage and absorbs that stage's variable latency.

---
 rtl/phase_unfold_if.sv | 34 +++
 rtl/phase_unfold.sv | 98 +++++++++
 tb/tb_phase_unfold.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/phase_unfold_if.sv
// phase_unfold bus: octant-flag / atan inputs, unfolded phase and FIFO status outputs.
// Master drives samples, slave is the unfold block.
interface phase_unfold_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          flag_val_i;
  logic [2:0]    case_flag_i;
  logic          atan_val_i;
  logic [7:0]    atan_i;
  logic          val_o;
  logic [10:0]   phase_o;
  logic          fifo_full_o;
  logic          fifo_empty_o;
  logic [LW-1:0] level_o;
  logic          err_o;

  modport master (
    output flag_val_i, case_flag_i,
    output atan_val_i, atan_i,
    input  val_o, phase_o,
    input  fifo_full_o, fifo_empty_o,
    input  level_o, err_o
  );

  modport slave (
    input  flag_val_i, case_flag_i,
    input  atan_val_i, atan_i,
    output val_o, phase_o,
    output fifo_full_o, fifo_empty_o,
    output level_o, err_o
  );
endinterface

// File: rtl/phase_unfold.sv
// Re-aligns octant flags with atan results and unfolds to a 2048-unit phase.
// Define PHASE_UNFOLD_ERR_EN to build the sticky overflow/underflow flag err_o.
module phase_unfold #(
  parameter int DEPTH = 16
) (
  input logic       clk,
  input logic       rst_n,
  phase_unfold_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [2:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] lvl_q, lvl_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          val_q, val_d;
  logic [10:0]   phase_q, phase_d;

  logic          is_empty, is_full;
  logic          bypass, do_pop, do_push;
  logic [2:0]    k;
  logic [10:0]   sum;

  always_comb begin
    is_empty = (wr_q == rd_q);
    is_full  = (wr_q[AW] != rd_q[AW]) &&
               (wr_q[AW-1:0] == rd_q[AW-1:0]);
    bypass   = bus.flag_val_i & bus.atan_val_i & is_empty;
    do_pop   = bus.atan_val_i & ~is_empty;
    // A pop frees the slot in the same cycle, so a full push may land.
    do_push  = bus.flag_val_i & ~bypass & (~is_full | do_pop);
    k        = bypass ? bus.case_flag_i : mem_q[rd_q[AW-1:0]];
    if (k[0])
      sum = {k, 8'h00} + 11'd256 - {3'b000, bus.atan_i};
    else
      sum = {k, 8'h00} + {3'b000, bus.atan_i};
    wr_d    = wr_q + PW'(do_push);
    rd_d    = rd_q + PW'(do_pop);
    lvl_d   = wr_d - rd_d;
    empty_d = (wr_d == rd_d);
    full_d  = (lvl_d == PW'(DEPTH));
    val_d   = bypass | do_pop;
    phase_d = val_d ? sum : phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push)
      mem_q[wr_q[AW-1:0]] <= bus.case_flag_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      val_q   <= 1'b0;
      phase_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      val_q   <= val_d;
      phase_q <= phase_d;
    end
  end

  assign bus.val_o        = val_q;
  assign bus.phase_o      = phase_q;
  assign bus.level_o      = lvl_q;
  assign bus.fifo_full_o  = full_q;
  assign bus.fifo_empty_o = empty_q;

`ifdef PHASE_UNFOLD_ERR_EN
  logic err_q;
  logic ovf, udf;

  assign ovf = bus.flag_val_i & is_full & ~bus.atan_val_i;
  assign udf = bus.atan_val_i & ~bus.flag_val_i & is_empty;

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (ovf | udf)
      err_q <= 1'b1;
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_phase_unfold.sv
// Scoreboard bench for phase_unfold: directed vectors plus a modelled random soak.
// Expected phases are queued at issue time and popped by an output monitor.
module tb_phase_unfold;
  localparam int DEPTH = 16;
`ifdef PHASE_UNFOLD_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_q[$];

  phase_unfold_if #(.DEPTH(DEPTH)) bus ();

  phase_unfold #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int unfold(int k, int a);
    if (k % 2 == 1)
      return ((k + 1) * 256 - a) % 2048;
    return (k * 256 + a) % 2048;
  endfunction

  task automatic cyc(bit fv, int k, bit av, int a);
    bus.flag_val_i  = fv;
    bus.case_flag_i = 3'(k);
    bus.atan_val_i  = av;
    bus.atan_i      = 8'(a);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.val_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_val: got phase %0h expected no output",
                 bus.phase_o);
      end else begin
        chk("phase", int'(bus.phase_o), exp_q.pop_front());
      end
    end
  end

  initial begin
    int mq[$];
    int pushed, popped, f, k, a;
    bit p, q, byp;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.flag_val_i  = 1'b0;
    bus.case_flag_i = '0;
    bus.atan_val_i  = 1'b0;
    bus.atan_i      = '0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_val", int'(bus.val_o), 0);
    chk("rst_phase", int'(bus.phase_o), 0);
    chk("rst_level", int'(bus.level_o), 0);
    chk("rst_empty", int'(bus.fifo_empty_o), 1);
    chk("rst_full", int'(bus.fifo_full_o), 0);
    chk("rst_err", int'(bus.err_o), 0);
    rst_n = 1'b1;

    // bypass octant sweep
    exp_q.push_back('h040); cyc(1, 0, 1, 'h40);
    exp_q.push_back('h1C0); cyc(1, 1, 1, 'h40);
    exp_q.push_back('h3F0); cyc(1, 3, 1, 'h10);
    exp_q.push_back('h480); cyc(1, 4, 1, 'h80);
    exp_q.push_back('h000); cyc(1, 7, 1, 'h00);
    chk("bypass_level", int'(bus.level_o), 0);
    cyc(0, 0, 0, 0);

    // latency alignment
    for (int i = 0; i < 5; i++) cyc(1, i, 0, 0);
    chk("lat_level5", int'(bus.level_o), 5);
    chk("lat_empty", int'(bus.fifo_empty_o), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    exp_q.push_back('h020); cyc(0, 0, 1, 'h20);
    exp_q.push_back('h1E0); cyc(0, 0, 1, 'h20);
    exp_q.push_back('h220); cyc(0, 0, 1, 'h20);
    exp_q.push_back('h3E0); cyc(0, 0, 1, 'h20);
    exp_q.push_back('h420); cyc(0, 0, 1, 'h20);
    chk("lat_level0", int'(bus.level_o), 0);
    chk("lat_empty0", int'(bus.fifo_empty_o), 1);
    cyc(0, 0, 0, 0);

    // full boundary: flag 16 (k=0) is dropped
    for (int i = 0; i <= DEPTH; i++) cyc(1, i % 8, 0, 0);
    chk("full_flag", int'(bus.fifo_full_o), 1);
    chk("full_level", int'(bus.level_o), DEPTH);
    chk("full_err", int'(bus.err_o), int'(ERR_ON));
    exp_q.push_back('h030); cyc(1, 5, 1, 'h30);
    chk("full_pp_level", int'(bus.level_o), DEPTH);
    chk("full_pp_flag", int'(bus.fifo_full_o), 1);
    for (int i = 1; i < DEPTH; i++) begin
      exp_q.push_back(unfold(i % 8, 'h30));
      cyc(0, 0, 1, 'h30);
    end
    exp_q.push_back(unfold(5, 'h30)); cyc(0, 0, 1, 'h30);
    chk("drain_level", int'(bus.level_o), 0);
    cyc(0, 0, 0, 0);

    // underflow
    cyc(0, 0, 1, 'h55);
    chk("udf_val", int'(bus.val_o), 0);
    chk("udf_level", int'(bus.level_o), 0);
    chk("udf_err", int'(bus.err_o), int'(ERR_ON));
    cyc(0, 0, 0, 0);

    // reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1, i + 3, 0, 0);
    chk("pre_rst_level", int'(bus.level_o), 3);
    rst_n = 1'b0;
    cyc(0, 0, 1, 'h10);
    rst_n = 1'b1;
    chk("mrst_val", int'(bus.val_o), 0);
    chk("mrst_phase", int'(bus.phase_o), 0);
    chk("mrst_level", int'(bus.level_o), 0);
    chk("mrst_empty", int'(bus.fifo_empty_o), 1);
    chk("mrst_full", int'(bus.fifo_full_o), 0);
    chk("mrst_err", int'(bus.err_o), 0);
    exp_q.push_back('h210); cyc(1, 2, 1, 'h10);
    cyc(0, 0, 0, 0);

    // random soak against a flag-queue model
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 20000 && popped < 1024; c++) begin
      p = (pushed < 1024) && ($urandom_range(0, 1) == 1);
      q = ($urandom_range(0, 1) == 1);
      k = $urandom_range(0, 7);
      a = $urandom_range(0, 255);
      if (p && !q && mq.size() >= DEPTH) p = 1'b0;
      if (q && !p && mq.size() == 0) q = 1'b0;
      byp = p && q && mq.size() == 0;
      if (q) begin
        if (byp) f = k;
        else f = mq.pop_front();
        exp_q.push_back(unfold(f, a));
        popped++;
      end
      if (p) begin
        if (!byp) mq.push_back(k);
        pushed++;
      end
      cyc(p, k, q, a);
    end
    chk("soak_done", popped, 1024);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("soak_err", int'(bus.err_o), 0);
    chk("soak_level", int'(bus.level_o), mq.size());
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
